// File: rtl/mem_arbiter_if.sv
// Bundle of the per-port request signals and the shared main-memory port.
// The arbiter sits on the slave modport; requesters and the memory drive
// the master modport.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64,
    parameter int PORT_COUNT = 2,
    parameter int PORT_BITS  = 3
);
    logic [PORT_COUNT*ADDR_WIDTH-1:0] addr;
    logic [PORT_COUNT*WORD_WIDTH-1:0] din;
    logic [PORT_COUNT*WORD_WIDTH-1:0] dout;
    logic [PORT_COUNT-1:0]            re;
    logic [PORT_COUNT-1:0]            we;
    logic [PORT_COUNT-1:0]            ready;
    logic [ADDR_WIDTH-1:0]            maddr;
    logic [WORD_WIDTH-1:0]            mout;
    logic [WORD_WIDTH-1:0]            min;
    logic                             mre;
    logic                             mwe;
    logic                             mready;
    logic [PORT_BITS-1:0]             grant;
    logic                             busy;

    modport slave (
        input  addr, din, re, we, min, mready,
        output dout, ready, maddr, mout, mre, mwe, grant, busy
    );

    modport master (
        output addr, din, re, we, min, mready,
        input  dout, ready, maddr, mout, mre, mwe, grant, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between PORT_COUNT
// single-outstanding requesters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no transaction; pick a pending port when memory is ready
// S_ISSUE | one-cycle strobe (mre or mwe) is on the memory port
// S_WAIT  | waiting for mready; complete, free the port, back to idle
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64,
    parameter int PORT_COUNT = 2,
    parameter int PORT_BITS  = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]                       state;
    logic [PORT_COUNT-1:0]            pend;
    logic [PORT_COUNT-1:0]            slot_wr;
    logic [ADDR_WIDTH-1:0]            slot_addr [PORT_COUNT];
    logic [WORD_WIDTH-1:0]            slot_data [PORT_COUNT];
    logic [PORT_BITS-1:0]             rr_ptr;
    logic [PORT_BITS-1:0]             grant_q;
    logic                             cur_wr;
    logic                             mre_q;
    logic                             mwe_q;
    logic                             busy_q;
    logic [ADDR_WIDTH-1:0]            maddr_q;
    logic [WORD_WIDTH-1:0]            mout_q;
    logic [PORT_COUNT*WORD_WIDTH-1:0] dout_q;

    logic [PORT_BITS-1:0]             win;
    logic [ADDR_WIDTH-1:0]            win_addr;
    logic [WORD_WIDTH-1:0]            win_data;
    logic                             win_wr;
    logic                             win_found;
    int                               idx;

    // A port is ready exactly when it has no latched request.
    assign bus.ready = ~pend;
    assign bus.dout  = dout_q;
    assign bus.maddr = maddr_q;
    assign bus.mout  = mout_q;
    assign bus.mre   = mre_q;
    assign bus.mwe   = mwe_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;

    // Winner search: first pending port after rr_ptr, wrapping modulo PORT_COUNT.
    always_comb begin
        win       = '0;
        win_addr  = '0;
        win_data  = '0;
        win_wr    = 1'b0;
        win_found = 1'b0;
        idx       = 0;
        for (int i = 1; i <= PORT_COUNT; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= PORT_COUNT) idx = idx - PORT_COUNT;
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (!win_found && p == idx && pend[p]) begin
                    win_found = 1'b1;
                    win       = PORT_BITS'(p);
                    win_addr  = slot_addr[p];
                    win_data  = slot_data[p];
                    win_wr    = slot_wr[p];
                end
            end
        end
    end

    // Request capture, transaction sequencing and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pend    <= '0;
            slot_wr <= '0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                slot_addr[p] <= '0;
                slot_data[p] <= '0;
            end
            rr_ptr  <= PORT_BITS'(PORT_COUNT - 1);
            grant_q <= '0;
            cur_wr  <= 1'b0;
            mre_q   <= 1'b0;
            mwe_q   <= 1'b0;
            busy_q  <= 1'b0;
            maddr_q <= '0;
            mout_q  <= '0;
            dout_q  <= '0;
        end else begin
            mre_q <= 1'b0;
            mwe_q <= 1'b0;

            // A simultaneous re+we is recorded as a write.
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (!pend[p] && (bus.re[p] || bus.we[p])) begin
                    pend[p]      <= 1'b1;
                    slot_wr[p]   <= bus.we[p];
                    slot_addr[p] <= bus.addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                    slot_data[p] <= bus.din[p*WORD_WIDTH +: WORD_WIDTH];
                end
            end

            case (state)
                S_IDLE: begin
                    if (win_found && bus.mready) begin
                        grant_q <= win;
                        maddr_q <= win_addr;
                        mout_q  <= win_data;
                        mre_q   <= !win_wr;
                        mwe_q   <= win_wr;
                        cur_wr  <= win_wr;
                        busy_q  <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mready) begin
                        // Completion only touches the granted port, which is
                        // pending and so cannot be capturing on this edge.
                        for (int p = 0; p < PORT_COUNT; p++) begin
                            if (grant_q == PORT_BITS'(p)) begin
                                pend[p] <= 1'b0;
                                if (!cur_wr) dout_q[p*WORD_WIDTH +: WORD_WIDTH] <= bus.min;
                            end
                        end
                        busy_q <= 1'b0;
                        rr_ptr <= grant_q;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a scoreboard queue of expected memory strobes,
// a table of single-port transactions, and hand-written multi-port and
// reset sequences.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int WW = 64;
    localparam int PC = 2;
    localparam int PB = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .PORT_COUNT(PC), .PORT_BITS(PB)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .PORT_COUNT(PC), .PORT_BITS(PB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          port;
        bit          wr;
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } exp_t;

    typedef struct {
        int          port;
        bit          rd;
        bit          wr;
        logic [AW-1:0] a;
        logic [WW-1:0] d;
        logic [WW-1:0] mval;
        int          wait_cyc;
        logic [WW-1:0] exp_dout;
        int          exp_lat;
    } vec_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors  = 0;
    int   checks  = 0;
    int   strobes = 0;
    int   wait_cfg = 0;
    int   wcnt = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(int p, bit r, bit w, logic [AW-1:0] a, logic [WW-1:0] d);
        bus.addr[p*AW +: AW] = a;
        bus.din[p*WW +: WW]  = d;
        bus.re[p] = r;
        bus.we[p] = w;
        step();
        bus.re[p] = 1'b0;
        bus.we[p] = 1'b0;
    endtask

    task automatic wait_ready(int p, int limit, output int lat);
        lat = 1;
        while (bus.ready[p] !== 1'b1 && lat < limit) begin
            step();
            lat++;
        end
        if (bus.ready[p] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout port %0d: ready=0 after %0d cycles, expected 1", p, lat);
        end
    endtask

    // Memory model: after a strobe, hold mready low for wait_cfg cycles.
    always @(posedge clk) begin
        if (rst) begin
            bus.mready <= 1'b1;
            wcnt       <= 0;
        end else if ((bus.mre || bus.mwe) && wait_cfg > 0) begin
            bus.mready <= 1'b0;
            wcnt       <= wait_cfg - 1;
        end else if (!bus.mready) begin
            if (wcnt == 0) bus.mready <= 1'b1;
            else wcnt <= wcnt - 1;
        end
    end

    // Strobe monitor: every strobe must match the next expected transaction.
    always @(negedge clk) begin
        if (rst === 1'b0 && (bus.mre === 1'b1 || bus.mwe === 1'b1)) begin
            strobes++;
            chk("strobe_exclusive", 64'(bus.mre & bus.mwe), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got grant=%0d maddr=%h, expected no strobe", bus.grant, bus.maddr);
            end else begin
                e = exp_q.pop_front();
                chk("grant", 64'(bus.grant), 64'(e.port));
                chk("strobe_is_write", 64'(bus.mwe), 64'(e.wr));
                chk("maddr", bus.maddr, e.a);
                if (e.wr) chk("mout", bus.mout, e.d);
            end
        end
    end

    initial begin
        vec_t vecs[6];
        logic [WW-1:0] exp_dout [PC];
        int lat;
        int s0;
        int n_req [PC];
        int cyc;
        exp_t x;

        vecs[0] = '{1, 0, 1, 64'h40, 64'h55, 64'h0, 5, 64'h0, 9};
        vecs[1] = '{1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0123_4567_89AB_CDEF, 2, 64'h0123_4567_89AB_CDEF, 6};
        vecs[2] = '{0, 1, 1, 64'h8000_0000_0000_0000, 64'hA5A5_5A5A_0000_FFFF, 64'h0, 0, 64'hDEAD, 4};
        vecs[3] = '{0, 1, 0, 64'h0, 64'h0, 64'h0, 3, 64'h0, 7};
        vecs[4] = '{0, 1, 0, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'hCAFE_F00D_0000_0001, 0, 64'hCAFE_F00D_0000_0001, 4};
        vecs[5] = '{1, 0, 1, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 64'h0123_4567_89AB_CDEF, 5};

        rst = 1'b1;
        bus.re = '0;
        bus.we = '0;
        bus.addr = '0;
        bus.din = '0;
        bus.min = '0;
        for (int p = 0; p < PC; p++) exp_dout[p] = '0;

        // Reset then idle
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 64'(bus.ready), 64'b11);
        chk("rst_mre", 64'(bus.mre), 64'd0);
        chk("rst_mwe", 64'(bus.mwe), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_dout0", bus.dout[0 +: WW], 64'd0);
        chk("rst_dout1", bus.dout[WW +: WW], 64'd0);
        s0 = strobes;
        repeat (10) step();
        chk("idle_no_strobe", 64'(strobes - s0), 64'd0);

        // Single read, zero-wait: exact cycle timing
        wait_cfg = 0;
        bus.min = 64'hDEAD;
        exp_q.push_back('{0, 1'b0, 64'h100, 64'h0});
        req(0, 1'b1, 1'b0, 64'h100, 64'h0);
        chk("c1_ready0", 64'(bus.ready[0]), 64'd0);
        step();
        chk("c2_mre", 64'(bus.mre), 64'd1);
        chk("c2_maddr", bus.maddr, 64'h100);
        step();
        chk("c3_busy", 64'(bus.busy), 64'd1);
        chk("c3_ready0", 64'(bus.ready[0]), 64'd0);
        step();
        chk("c4_ready0", 64'(bus.ready[0]), 64'd1);
        chk("c4_dout0", bus.dout[0 +: WW], 64'hDEAD);
        chk("c4_busy", 64'(bus.busy), 64'd0);
        exp_dout[0] = 64'hDEAD;

        // Table of single-port transactions
        for (int i = 0; i < 6; i++) begin
            wait_cfg = vecs[i].wait_cyc;
            bus.min  = vecs[i].mval;
            exp_q.push_back('{vecs[i].port, vecs[i].wr, vecs[i].a, vecs[i].d});
            s0 = strobes;
            req(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
            wait_ready(vecs[i].port, 60, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_dout", i), bus.dout[vecs[i].port*WW +: WW], vecs[i].exp_dout);
            chk($sformatf("vec%0d_strobes", i), 64'(strobes - s0), 64'd1);
            chk($sformatf("vec%0d_queue", i), 64'(exp_q.size()), 64'd0);
            chk($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd0);
            if (vecs[i].rd && !vecs[i].wr) exp_dout[vecs[i].port] = vecs[i].mval;
        end

        // Simultaneous requests, twice; pointer sits at 1 so port 0 wins each time
        wait_cfg = 0;
        for (int k = 0; k < 2; k++) begin
            bus.min = (k == 0) ? 64'h1234 : 64'h5678;
            exp_q.push_back('{0, 1'b0, 64'hA00 + 64'(k*8), 64'h0});
            exp_q.push_back('{1, 1'b0, 64'hB00 + 64'(k*8), 64'h0});
            bus.addr[0 +: AW]  = 64'hA00 + 64'(k*8);
            bus.addr[AW +: AW] = 64'hB00 + 64'(k*8);
            bus.re = 2'b11;
            step();
            bus.re = 2'b00;
            step(); step(); step();
            chk($sformatf("pair%0d_c4_ready", k), 64'(bus.ready), 64'b01);
            step(); step(); step();
            chk($sformatf("pair%0d_c7_ready", k), 64'(bus.ready), 64'b11);
            chk($sformatf("pair%0d_dout0", k), bus.dout[0 +: WW], bus.min);
            chk($sformatf("pair%0d_dout1", k), bus.dout[WW +: WW], bus.min);
            chk($sformatf("pair%0d_queue", k), 64'(exp_q.size()), 64'd0);
        end

        // Fairness: both ports re-request the cycle their ready returns
        bus.min = 64'hF00D;
        n_req[0] = 0;
        n_req[1] = 0;
        s0 = strobes;
        cyc = 0;
        while (!(n_req[0] == 4 && n_req[1] == 4 && bus.ready == 2'b11) && cyc < 200) begin
            for (int p = 0; p < PC; p++) begin
                if (bus.ready[p] && n_req[p] < 4) begin
                    x = '{p, 1'b0, 64'h1000 + 64'(p*16 + n_req[p]), 64'h0};
                    exp_q.push_back(x);
                    bus.addr[p*AW +: AW] = x.a;
                    bus.re[p] = 1'b1;
                    n_req[p]++;
                end
            end
            step();
            bus.re = 2'b00;
            cyc++;
        end
        chk("fair_done_in_budget", 64'(cyc < 200), 64'd1);
        chk("fair_strobes", 64'(strobes - s0), 64'd8);
        chk("fair_queue", 64'(exp_q.size()), 64'd0);
        chk("fair_dout0", bus.dout[0 +: WW], 64'hF00D);
        chk("fair_dout1", bus.dout[WW +: WW], 64'hF00D);

        // Reset during WAIT abandons the transaction
        wait_cfg = 10;
        bus.min = 64'h0;
        exp_q.push_back('{1, 1'b0, 64'hC0, 64'h0});
        req(1, 1'b1, 1'b0, 64'hC0, 64'h0);
        step();
        step();
        chk("mid_busy", 64'(bus.busy), 64'd1);
        chk("mid_mready_low", 64'(bus.mready), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_ready", 64'(bus.ready), 64'b11);
        chk("rst2_busy", 64'(bus.busy), 64'd0);
        chk("rst2_dout0", bus.dout[0 +: WW], 64'd0);
        chk("rst2_dout1", bus.dout[WW +: WW], 64'd0);
        chk("rst2_queue", 64'(exp_q.size()), 64'd0);
        exp_dout[0] = '0;
        exp_dout[1] = '0;
        s0 = strobes;
        repeat (8) step();
        chk("rst2_no_strobe", 64'(strobes - s0), 64'd0);

        // re+we together after reset is a write
        wait_cfg = 0;
        exp_q.push_back('{0, 1'b1, 64'h3C0, 64'h77});
        s0 = strobes;
        req(0, 1'b1, 1'b1, 64'h3C0, 64'h77);
        wait_ready(0, 40, lat);
        chk("rw_latency", 64'(lat), 64'd4);
        chk("rw_strobes", 64'(strobes - s0), 64'd1);
        chk("rw_dout0", bus.dout[0 +: WW], exp_dout[0]);
        chk("rw_queue", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
